// File: rtl/lcd_nibble_ctrl.sv
// lcd_nibble_ctrl
// Timing engine for an HD44780-compatible character LCD driven in 4-bit mode.
// A single byte-write strobe from the CPU IO decode is turned into two E
// pulses (high nibble, gap, low nibble) followed by the controller execution
// wait. After reset the block can optionally run the 4-bit power-on init
// sequence on its own. The busy flag is high for the whole of init, transfer
// and execution wait, and is low exactly while the engine sits in IDLE.
//
// All T_* parameters are in sys_clk cycles and must be at least 1; the delay
// counter is loaded with T_x-1 on state entry and counts down to zero.

module lcd_nibble_ctrl #(
  parameter int INIT_EN   = 1,
  parameter int T_POWERON = 1080000,
  parameter int T_INIT1   = 110700,
  parameter int T_INIT2   = 2700,
  parameter int T_AS      = 2,
  parameter int T_PW      = 8,
  parameter int T_H       = 2,
  parameter int T_GAP     = 27,
  parameter int T_EXEC    = 1080,
  parameter int T_CLEAR   = 41040,
  parameter int CW        = 21
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic [3:0] lcd_db
);

  typedef enum logic [2:0] {
    S_INIT_WAIT = 3'd0,
    S_SETUP     = 3'd1,
    S_E_HIGH    = 3'd2,
    S_HOLD      = 3'd3,
    S_GAP       = 3'd4,
    S_EXEC      = 3'd5,
    S_IDLE      = 3'd6
  } state_t;

  // Counter reload values (cycles minus one, since the counter ends at zero)
  localparam logic [CW-1:0] LD_POWERON = CW'(T_POWERON - 1);
  localparam logic [CW-1:0] LD_INIT1   = CW'(T_INIT1 - 1);
  localparam logic [CW-1:0] LD_INIT2   = CW'(T_INIT2 - 1);
  localparam logic [CW-1:0] LD_AS      = CW'(T_AS - 1);
  localparam logic [CW-1:0] LD_PW      = CW'(T_PW - 1);
  localparam logic [CW-1:0] LD_H       = CW'(T_H - 1);
  localparam logic [CW-1:0] LD_GAP     = CW'(T_GAP - 1);
  localparam logic [CW-1:0] LD_EXEC    = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] LD_CLEAR   = CW'(T_CLEAR - 1);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};

  localparam logic          INIT_ON    = (INIT_EN != 0);
  localparam state_t        RST_STATE  = INIT_ON ? S_INIT_WAIT : S_IDLE;
  localparam logic [CW-1:0] RST_CNT    = INIT_ON ? LD_POWERON : CNT_ZERO;
  // Number of init nibbles; reaching it in INIT_WAIT ends the init sequence
  localparam logic [2:0]    INIT_LAST  = 3'd4;

  // Wait that follows an init nibble, indexed by how many nibbles are done
  function automatic logic [CW-1:0] init_wait_load(input logic [2:0] nib_done);
    logic [CW-1:0] ld;
    case (nib_done)
      3'd1:    ld = LD_INIT1;
      3'd2:    ld = LD_INIT2;
      default: ld = LD_EXEC;
    endcase
    return ld;
  endfunction

  // Clear display (0x01) and return home (0x02/0x03) need the long wait;
  // only commands qualify, a data byte of 0x01 is a normal write
  function automatic logic [CW-1:0] exec_load(input logic rs, input logic [7:0] b);
    logic [CW-1:0] ld;
    if (!rs && (b[7:2] == 6'd0)) begin
      ld = LD_CLEAR;
    end else begin
      ld = LD_EXEC;
    end
    return ld;
  endfunction

  // Init nibbles are 0x3, 0x3, 0x3 (8-bit resync) then 0x2 (switch to 4-bit)
  function automatic logic [3:0] init_nibble(input logic [2:0] nib_done);
    logic [3:0] nib;
    if (nib_done == 3'd3) begin
      nib = 4'h2;
    end else begin
      nib = 4'h3;
    end
    return nib;
  endfunction

  // Sequencer state
  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          init_r, init_s;      // init sequence in progress
  logic [2:0]    step_r, step_s;      // init nibbles completed
  logic          low_r, low_s;        // current nibble is the low one
  logic          rs_lat_r, rs_lat_s;  // register select latched at acceptance
  logic [7:0]    byte_r, byte_s;      // byte latched at acceptance
  logic          accept_s;
  logic          cnt_done_s;

  // Registered pin/flag outputs
  logic          e_r, e_s;
  logic          rs_r, rs_s;
  logic [3:0]    db_r, db_s;
  logic          busy_r, busy_s;
  logic          rw_r;

  assign cnt_done_s = (cnt_r == CNT_ZERO);

  // State register: sequencer state, delay counter and transfer context
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= RST_STATE;
      cnt_r    <= RST_CNT;
      init_r   <= INIT_ON;
      step_r   <= 3'd0;
      low_r    <= 1'b0;
      rs_lat_r <= 1'b0;
      byte_r   <= 8'h00;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      init_r   <= init_s;
      step_r   <= step_s;
      low_r    <= low_s;
      rs_lat_r <= rs_lat_s;
      byte_r   <= byte_s;
    end
  end

  // Next-state logic: advance on counter expiry, reload counter on entry
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_done_s ? cnt_r : (cnt_r - CNT_ONE);
    init_s   = init_r;
    step_s   = step_r;
    low_s    = low_r;
    rs_lat_s = rs_lat_r;
    byte_s   = byte_r;
    accept_s = 1'b0;
    case (state_r)
      S_INIT_WAIT: begin
        if (cnt_done_s) begin
          if (step_r == INIT_LAST) begin
            state_s = S_IDLE;
            init_s  = 1'b0;
          end else begin
            state_s = S_SETUP;
            cnt_s   = LD_AS;
          end
        end else begin
          state_s = S_INIT_WAIT;
        end
      end
      S_SETUP: begin
        if (cnt_done_s) begin
          state_s = S_E_HIGH;
          cnt_s   = LD_PW;
        end else begin
          state_s = S_SETUP;
        end
      end
      S_E_HIGH: begin
        if (cnt_done_s) begin
          state_s = S_HOLD;
          cnt_s   = LD_H;
        end else begin
          state_s = S_E_HIGH;
        end
      end
      S_HOLD: begin
        if (!cnt_done_s) begin
          state_s = S_HOLD;
        end else if (init_r) begin
          state_s = S_INIT_WAIT;
          step_s  = step_r + 3'd1;
          cnt_s   = init_wait_load(step_r + 3'd1);
        end else if (!low_r) begin
          state_s = S_GAP;
          cnt_s   = LD_GAP;
        end else begin
          state_s = S_EXEC;
          cnt_s   = exec_load(rs_lat_r, byte_r);
        end
      end
      S_GAP: begin
        if (cnt_done_s) begin
          state_s = S_SETUP;
          low_s   = 1'b1;
          cnt_s   = LD_AS;
        end else begin
          state_s = S_GAP;
        end
      end
      S_EXEC: begin
        if (cnt_done_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_EXEC;
        end
      end
      S_IDLE: begin
        // Writes outside IDLE are dropped simply by never reaching this branch
        if (wr && !busy_r) begin
          accept_s = 1'b1;
          state_s  = S_SETUP;
          cnt_s    = LD_AS;
          low_s    = 1'b0;
          rs_lat_s = wr_rs;
          byte_s   = wr_data;
        end else begin
          state_s  = S_IDLE;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = CNT_ZERO;
        init_s  = 1'b0;
      end
    endcase
  end

  // Output decode from the next state so the pins change with the state
  always_comb begin
    e_s    = (state_s == S_E_HIGH);
    busy_s = (state_s != S_IDLE);
    rs_s   = rs_r;
    db_s   = db_r;
    if (accept_s) begin
      rs_s = wr_rs;
      db_s = wr_data[7:4];
    end else if ((state_r == S_GAP) && (state_s == S_SETUP)) begin
      db_s = byte_r[3:0];
    end else if ((state_r == S_INIT_WAIT) && (state_s == S_SETUP)) begin
      rs_s = 1'b0;
      db_s = init_nibble(step_r);
    end else begin
      // RS/DB hold their value through SETUP, E_HIGH, HOLD, EXEC and IDLE
      rs_s = rs_r;
      db_s = db_r;
    end
  end

  // Output registers; reset clears E asynchronously, even mid-pulse
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      e_r    <= 1'b0;
      rs_r   <= 1'b0;
      db_r   <= 4'h0;
      busy_r <= INIT_ON;
      rw_r   <= 1'b0;
    end else begin
      e_r    <= e_s;
      rs_r   <= rs_s;
      db_r   <= db_s;
      busy_r <= busy_s;
      rw_r   <= 1'b0;
    end
  end

  assign lcd_e  = e_r;
  assign lcd_rs = rs_r;
  assign lcd_db = db_r;
  assign lcd_rw = rw_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_lcd_nibble_ctrl.sv
// Bench for lcd_nibble_ctrl. Two instances: A runs the init sequence with
// shortened timing and takes random writes; B starts idle with default
// timing and takes the directed transfers. A negedge monitor records every
// E pulse and every busy fall; a timeline model derived from the protocol
// rules predicts the same events.
module tb_lcd_nibble_ctrl;

  typedef struct {
    int         t;
    logic [3:0] db;
    logic       rs;
    int         w;
    logic       ok;
  } pulse_t;

  localparam int TAS = 2, TPW = 8, TH = 2, TGAP = 27;
  localparam int TPON = 50, TI1 = 20, TI2 = 10;

  logic        clk = 1'b0;
  logic        rst_a_n, rst_b_n;
  logic [1:0]  wr_v, wrs_v, e_v, busy_v, rw_v, rs_v;
  logic [15:0] wd_v;
  logic [7:0]  db_v;
  logic [1:0]  e_prev = 2'b00, busy_prev = 2'b00;

  int cyc = 0;
  int total = 0, bad = 0, rw_bad = 0;
  int tex[2], tcl[2], idle_from[2];

  pulse_t got_q[2][$];
  pulse_t exp_q[2][$];
  int     got_f[2][$];
  int     exp_f[2][$];
  pulse_t cur[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_nibble_ctrl #(.INIT_EN(1), .T_POWERON(TPON), .T_INIT1(TI1), .T_INIT2(TI2),
                    .T_EXEC(15), .T_CLEAR(40)) dut_a (
    .sys_clk(clk), .rst_n(rst_a_n), .wr(wr_v[0]), .wr_rs(wrs_v[0]), .wr_data(wd_v[7:0]),
    .busy(busy_v[0]), .lcd_e(e_v[0]), .lcd_rw(rw_v[0]), .lcd_rs(rs_v[0]), .lcd_db(db_v[3:0]));

  lcd_nibble_ctrl #(.INIT_EN(0)) dut_b (
    .sys_clk(clk), .rst_n(rst_b_n), .wr(wr_v[1]), .wr_rs(wrs_v[1]), .wr_data(wd_v[15:8]),
    .busy(busy_v[1]), .lcd_e(e_v[1]), .lcd_rw(rw_v[1]), .lcd_rs(rs_v[1]), .lcd_db(db_v[7:4]));

  // Monitor: record E pulses (rise cycle, DB/RS, width, stability) and busy falls
  always @(negedge clk) begin
    if (rw_v !== 2'b00) rw_bad <= rw_bad + 1;
    for (int i = 0; i < 2; i++) begin
      if (e_v[i] === 1'b1 && e_prev[i] !== 1'b1) begin
        cur[i].t  <= cyc;
        cur[i].db <= db_v[i*4 +: 4];
        cur[i].rs <= rs_v[i];
        cur[i].ok <= 1'b1;
      end else if (e_v[i] === 1'b1) begin
        if (db_v[i*4 +: 4] !== cur[i].db || rs_v[i] !== cur[i].rs) cur[i].ok <= 1'b0;
      end else if (e_prev[i] === 1'b1) begin
        got_q[i].push_back('{cur[i].t, cur[i].db, cur[i].rs, cyc - cur[i].t, cur[i].ok});
      end
      if (busy_prev[i] === 1'b1 && busy_v[i] === 1'b0) got_f[i].push_back(cyc);
    end
    e_prev    <= e_v;
    busy_prev <= busy_v;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Timeline model of one write sampled at clock edge k
  task automatic model_wr(input int i, input int k, input logic rs, input logic [7:0] d);
    pulse_t p;
    int     tw, nib;
    if (k >= idle_from[i]) begin
      nib = TAS + TPW + TH;
      tw  = (!rs && d[7:2] == 6'd0) ? tcl[i] : tex[i];
      p.rs = rs; p.w = TPW; p.ok = 1'b1;
      p.t = k + TAS;              p.db = d[7:4]; exp_q[i].push_back(p);
      p.t = k + nib + TGAP + TAS; p.db = d[3:0]; exp_q[i].push_back(p);
      exp_f[i].push_back(k + 2 * nib + TGAP + tw);
      idle_from[i] = k + 2 * nib + TGAP + tw + 1;
    end
  endtask

  // Timeline model of the init sequence after reset release at cycle c
  task automatic init_model(input int i, input int c);
    pulse_t p;
    int     t;
    int     nib[4];
    int     wt[4];
    nib = '{3, 3, 3, 2};
    wt  = '{TI1, TI2, tex[i], tex[i]};
    t = c + TPON;
    for (int j = 0; j < 4; j++) begin
      p.t = t + TAS; p.db = 4'(nib[j]); p.rs = 1'b0; p.w = TPW; p.ok = 1'b1;
      exp_q[i].push_back(p);
      t = t + TAS + TPW + TH + wt[j];
    end
    exp_f[i].push_back(t);
    idle_from[i] = t + 1;
  endtask

  // One-cycle write strobe; call at negedge+1, returns at the next negedge+1
  task automatic send(input int i, input logic rs, input logic [7:0] d);
    model_wr(i, cyc + 1, rs, d);
    wr_v[i] = 1'b1; wrs_v[i] = rs; wd_v[i*8 +: 8] = d;
    @(negedge clk); #1;
    wr_v[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy_v[i] !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk($sformatf("idle_timeout%0d", i), {31'd0, busy_v[i]}, 32'd0);
  endtask

  task automatic compare(input int i, input string tag);
    pulse_t g, e;
    chk($sformatf("%s_npulse", tag), got_q[i].size(), exp_q[i].size());
    for (int j = 0; j < exp_q[i].size(); j++) begin
      if (j < got_q[i].size()) begin
        g = got_q[i][j]; e = exp_q[i][j];
        chk($sformatf("%s_rise%0d", tag, j), g.t, e.t);
        chk($sformatf("%s_db%0d", tag, j), {28'd0, g.db}, {28'd0, e.db});
        chk($sformatf("%s_rs%0d", tag, j), {31'd0, g.rs}, {31'd0, e.rs});
        chk($sformatf("%s_width%0d", tag, j), g.w, e.w);
        chk($sformatf("%s_stable%0d", tag, j), {31'd0, g.ok}, 32'd1);
      end
    end
    chk($sformatf("%s_nfall", tag), got_f[i].size(), exp_f[i].size());
    for (int j = 0; j < exp_f[i].size(); j++) begin
      if (j < got_f[i].size()) chk($sformatf("%s_fall%0d", tag, j), got_f[i][j], exp_f[i][j]);
    end
    got_q[i].delete(); exp_q[i].delete(); got_f[i].delete(); exp_f[i].delete();
  endtask

  initial begin
    int         c, k0, k1, k2, k3, sp, w_n, sel;
    logic       rs;
    logic [7:0] d;
    tex[0] = 15;  tex[1] = 1080;
    tcl[0] = 40;  tcl[1] = 41040;
    idle_from[0] = 0; idle_from[1] = 0;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    wr_v = 2'b00; wrs_v = 2'b00; wd_v = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_a_busy", {31'd0, busy_v[0]}, 32'd1);
    chk("rst_a_e",    {31'd0, e_v[0]},    32'd0);
    chk("rst_a_rs",   {31'd0, rs_v[0]},   32'd0);
    chk("rst_a_db",   {28'd0, db_v[3:0]}, 32'd0);
    chk("rst_a_rw",   {31'd0, rw_v[0]},   32'd0);
    chk("rst_b_busy", {31'd0, busy_v[1]}, 32'd0);
    chk("rst_b_e",    {31'd0, e_v[1]},    32'd0);
    chk("rst_b_db",   {28'd0, db_v[7:4]}, 32'd0);
    rst_a_n = 1'b1; rst_b_n = 1'b1;

    // Interrupt A during E high of the second init nibble
    w_n = 0;
    while (!(got_q[0].size() == 1 && e_v[0] === 1'b1) && w_n < 300) begin
      @(negedge clk);
      w_n++;
    end
    chk("reach_nib2_e", {31'd0, e_v[0]}, 32'd1);
    #2;
    rst_a_n = 1'b0;
    #1;
    chk("async_e_low",   {31'd0, e_v[0]},    32'd0);
    chk("async_busy",    {31'd0, busy_v[0]}, 32'd1);
    chk("async_db_zero", {28'd0, db_v[3:0]}, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    got_q[0].delete(); got_f[0].delete(); exp_q[0].delete(); exp_f[0].delete();
    rst_a_n = 1'b1;
    c = cyc;
    init_model(0, c);
    wait_idle(0, 400);
    chk("init_busy_len", cyc - c, 158);
    compare(0, "init");

    // Random writes into A, including overlaps and clear/home commands
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(1, 90)) @(negedge clk);
      #1;
      rs  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 3);
      d   = (sel == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      send(0, rs, d);
    end
    wait_idle(0, 500);
    compare(0, "rand");

    // Directed transfers on B with default timing
    send(1, 1'b1, 8'h41);
    k0 = cyc;
    chk("acc_busy", {31'd0, busy_v[1]}, 32'd1);
    chk("acc_db",   {28'd0, db_v[7:4]}, 32'd4);
    chk("acc_rs",   {31'd0, rs_v[1]},   32'd1);
    repeat (4) @(negedge clk);
    #1;
    send(1, 1'b1, 8'h55);
    wait_idle(1, 2000);
    chk("len_data41", cyc - k0, 1131);
    send(1, 1'b0, 8'h01);
    k1 = cyc;
    chk("first_idle_acc_busy", {31'd0, busy_v[1]}, 32'd1);
    chk("first_idle_acc_db",   {28'd0, db_v[7:4]}, 32'd0);
    wait_idle(1, 45000);
    chk("len_clear", cyc - k1, 41091);
    send(1, 1'b1, 8'h01);
    k2 = cyc;
    wait_idle(1, 2000);
    chk("len_data01", cyc - k2, 1131);
    send(1, 1'b0, 8'h28);
    k3 = cyc;
    wait_idle(1, 2000);
    chk("len_cmd28", cyc - k3, 1131);
    sp = (got_q[1].size() >= 2) ? (got_q[1][1].t - got_q[1][0].t) : -1;
    chk("e_rise_spacing", sp, 39);
    compare(1, "dir");

    chk("rw_always_zero", rw_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
